// File: rtl/asyc_fifo.sv
// Single-clock FIFO with wrap-flag pointers, registered read data and a one-cycle valid strobe.
// Full/empty are decoded from the registered pointers, so they change only on clk edges.
module asyc_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_EN,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    input  logic             rd_EN,
    output logic [WIDTH-1:0] data_out,
    output logic             Dout_valid,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             dout_valid_q, dout_valid_d;

    logic             wr_accept;
    logic             rd_accept;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Equal index with differing wrap flags means the writer is a full lap ahead.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

    assign wr_accept = wr_EN && !full;
    assign rd_accept = rd_EN && !empty;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        data_out_d   = data_out_q;
        dout_valid_d = 1'b0;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            data_out_d   = mem[rd_idx];
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_out_q   <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_out_q   <= data_out_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Storage is intentionally not reset; pointer reset alone discards its contents.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_idx] <= data_in;
        end
    end

    assign data_out   = data_out_q;
    assign Dout_valid = dout_valid_q;

endmodule

// File: tb/tb_asyc_fifo.sv
// Self-checking bench for asyc_fifo: directed boundary cases plus random traffic
// compared against a queue-based reference model.
module tb_asyc_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             wr_EN;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             rd_EN;
    logic [WIDTH-1:0] data_out;
    logic             Dout_valid;
    logic             empty;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_valid;

    asyc_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_EN     (wr_EN),
        .data_in   (data_in),
        .full      (full),
        .rd_EN     (rd_EN),
        .data_out  (data_out),
        .Dout_valid(Dout_valid),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
        check({tag, ".valid"}, 32'(Dout_valid), 32'(exp_valid));
        check({tag, ".dout"}, 32'(data_out), 32'(exp_dout));
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
    endtask

    // One clock cycle: drive at negedge, decide acceptance from pre-edge occupancy, check after edge.
    task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] din, input string tag);
        bit wr_acc;
        bit rd_acc;
        @(negedge clk);
        wr_EN   = wr;
        rd_EN   = rd;
        data_in = din;
        wr_acc  = wr && (model_q.size() < DEPTH);
        rd_acc  = rd && (model_q.size() > 0);
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        if (rd_acc) begin
            exp_dout  = model_q.pop_front();
            exp_valid = 1'b1;
        end
        if (wr_acc) model_q.push_back(din);
        check_outputs(tag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        wr_EN    = 1'b0;
        rd_EN    = 1'b0;
        data_in  = '0;
        model_reset();

        // Reset held with random enables: outputs must stay at reset values.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_EN   = 1'($urandom);
            rd_EN   = 1'($urandom);
            data_in = WIDTH'($urandom);
            @(posedge clk);
            #1;
            check_outputs("reset");
        end
        @(negedge clk);
        wr_EN = 1'b0;
        rd_EN = 1'b0;
        rst_n = 1'b1;

        // Fill, then overflow attempt.
        for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, WIDTH'(8'h11 * k), "fill");
        step(1'b1, 1'b0, 8'h99, "overflow");
        step(1'b0, 1'b0, 8'h00, "idle_full");

        // Drain 9 times: the last read underflows and must hold 0x88.
        for (int k = 1; k <= 9; k++) step(1'b0, 1'b1, 8'h00, "drain");
        check("drain.hold", 32'(data_out), 32'h88);

        // Three stored, then 20 cycles of concurrent read/write across pointer wraps.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, WIDTH'(8'h40 + k), "pre3");
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, WIDTH'(8'h43 + k), "wrap");
        check("wrap.occupancy", 32'(model_q.size()), 32'd3);

        // Asynchronous reset mid-transfer, applied away from a clock edge.
        @(negedge clk);
        wr_EN = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        wr_EN = 1'b0;
        rst_n = 1'b1;

        // Both enables while full, then both enables while empty.
        for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, WIDTH'($urandom), "fill2");
        step(1'b1, 1'b1, 8'hAA, "both_full");
        for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, 8'h00, "drain2");
        step(1'b1, 1'b1, 8'h5A, "both_empty");
        step(1'b0, 1'b1, 8'h00, "after_empty");

        // Bursty producer, half-rate consumer, then drain the rest.
        for (int k = 0; k < 40; k++) step(1'b1, 1'((k % 2) == 1), WIDTH'($urandom), "burst");
        for (int k = 0; k < DEPTH + 2; k++) step(1'b0, 1'b1, 8'h00, "burst_drain");

        // Fully random traffic.
        for (int k = 0; k < 200; k++) step(1'($urandom), 1'($urandom), WIDTH'($urandom), "rand");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
